// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with busy scoreboard and saturating x0-write counter.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rd_busy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  output logic [NREGS-1:0]    busy,
  output logic [7:0]          x0_wr_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_set;
  logic [NREGS-1:0] busy_clr;
  logic [NREGS-1:0] busy_nxt;
  logic [1:0]       x0_inc;
  logic [8:0]       cnt_sum;
  logic [7:0]       cnt_nxt;

  // Issue beats a same-cycle writeback: the issue names a newer producer.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    x0_inc   = '0;
    if (iss_valid) busy_set[iss_addr] = 1'b1;
    for (int unsigned k = 0; k < NWR; k++) begin
      if (we[k]) begin
        busy_clr[wa[k*AW +: AW]] = 1'b1;
        if (wa[k*AW +: AW] == '0) x0_inc = x0_inc + 2'd1;
      end
    end
    busy_nxt    = (busy & ~busy_clr) | busy_set;
    busy_nxt[0] = 1'b0;
    cnt_sum     = {1'b0, x0_wr_cnt} + {7'b0, x0_inc};
    cnt_nxt     = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  // Ascending port order makes the highest-numbered port win an address conflict.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREGS; r++) regs[r] <= '0;
      busy      <= '0;
      x0_wr_cnt <= '0;
    end else begin
      for (int unsigned k = 0; k < NWR; k++) begin
        if (we[k] && wa[k*AW +: AW] != '0) regs[wa[k*AW +: AW]] <= wd[k*XLEN +: XLEN];
      end
      busy      <= busy_nxt;
      x0_wr_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int unsigned j = 0; j < NRD; j++) begin
      if (ra[j*AW +: AW] != '0) begin
        rd[j*XLEN +: XLEN] = regs[ra[j*AW +: AW]];
        rd_busy[j]         = busy[ra[j*AW +: AW]];
      end
`ifdef REGFILE_BYPASS_EN
      for (int unsigned k = 0; k < NWR; k++) begin
        if (ra[j*AW +: AW] != '0 && we[k] && wa[k*AW +: AW] == ra[j*AW +: AW]) begin
          rd[j*XLEN +: XLEN] = wd[k*XLEN +: XLEN];
          rd_busy[j]         = 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp built with two read and two write ports.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   wa;
  logic [NWR*XLEN-1:0] wd;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rd_busy;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic [NREGS-1:0]    busy;
  logic [7:0]          x0_wr_cnt;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
    .rd_busy(rd_busy), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .busy(busy), .x0_wr_cnt(x0_wr_cnt)
  );

  logic [63:0] exp_q[$];
  logic [63:0] exp_v;
  logic [63:0] obs;
  int          n_checks = 0;
  int          n_pass   = 0;

  logic [31:0] m_regs [NREGS];
  logic [31:0] m_busy;
  int          m_cnt;
  logic [4:0]  a;
  logic        m_clr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; wa = '0; wd = '0; iss_valid = 1'b0; iss_addr = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); ra = '0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    exp_q.push_back(64'd0); obs = 64'(busy); exp_v = exp_q.pop_front(); n_checks++;
    if (obs !== exp_v) $display("FAIL reset_busy: got %h expected %h", obs, exp_v); else n_pass++;
    exp_q.push_back(64'd0); obs = 64'(x0_wr_cnt); exp_v = exp_q.pop_front(); n_checks++;
    if (obs !== exp_v) $display("FAIL reset_cnt: got %h expected %h", obs, exp_v); else n_pass++;
    for (int i = 0; i < NREGS; i++) begin
      ra = {5'(i), 5'(NREGS - 1 - i)};
      #1;
      exp_q.push_back(64'd0);
      exp_q.push_back(64'd0);
      obs = {rd[63:32], rd[31:0]}; exp_v = {exp_q.pop_front() << 32} | exp_q.pop_front(); n_checks++;
      if (obs !== exp_v || rd_busy !== 2'b00)
        $display("FAIL reset_read[%0d]: got %h busy %b expected %h busy 00", i, obs, rd_busy, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_basic_write();
    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'hDEADBEEF}; ra = {5'd0, 5'd5};
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(64'hDEADBEEF);
`else
    exp_q.push_back(64'h0);
`endif
    obs = 64'(rd[31:0]); exp_v = exp_q.pop_front(); n_checks++;
    if (obs !== exp_v) $display("FAIL write_cycle_read: got %h expected %h", obs, exp_v); else n_pass++;
    tick(); idle();
    #1;
    exp_q.push_back(64'hDEADBEEF); obs = 64'(rd[31:0]); exp_v = exp_q.pop_front(); n_checks++;
    if (obs !== exp_v) $display("FAIL basic_read5: got %h expected %h", obs, exp_v); else n_pass++;
    exp_q.push_back(64'h0); obs = 64'(rd[63:32]); exp_v = exp_q.pop_front(); n_checks++;
    if (obs !== exp_v) $display("FAIL basic_read0: got %h expected %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_conflict();
    we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h2222, 32'h1111};
    tick();
    we = 2'b11; wa = {5'd9, 5'd8}; wd = {32'hAAAA_0009, 32'hBBBB_0008};
    tick(); idle(); ra = {5'd7, 5'd7};
    #1;
    exp_q.push_back(64'h2222); obs = 64'(rd[31:0]); exp_v = exp_q.pop_front(); n_checks++;
    if (obs !== exp_v) $display("FAIL conflict_port1_wins: got %h expected %h", obs, exp_v); else n_pass++;
    ra = {5'd9, 5'd8};
    #1;
    exp_q.push_back({32'hAAAA_0009, 32'hBBBB_0008}); obs = rd; exp_v = exp_q.pop_front(); n_checks++;
    if (obs !== exp_v) $display("FAIL dual_write: got %h expected %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_scoreboard();
    iss_valid = 1'b1; iss_addr = 5'd3;
    tick(); idle(); ra = {5'd5, 5'd3};
    #1;
    exp_q.push_back(64'h8); obs = 64'(busy); exp_v = exp_q.pop_front(); n_checks++;
    if (obs !== exp_v) $display("FAIL issue_busy: got %h expected %h", obs, exp_v); else n_pass++;
    exp_q.push_back(64'b01); obs = 64'(rd_busy); exp_v = exp_q.pop_front(); n_checks++;
    if (obs !== exp_v) $display("FAIL issue_rd_busy: got %h expected %h", obs, exp_v); else n_pass++;
    we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'h33}; iss_valid = 1'b1; iss_addr = 5'd3;
    tick(); idle();
    exp_q.push_back(64'h8); obs = 64'(busy); exp_v = exp_q.pop_front(); n_checks++;
    if (obs !== exp_v) $display("FAIL set_beats_clr: got %h expected %h", obs, exp_v); else n_pass++;
    we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'h34};
    tick(); idle();
    exp_q.push_back(64'h0); obs = 64'(busy); exp_v = exp_q.pop_front(); n_checks++;
    if (obs !== exp_v) $display("FAIL write_clears: got %h expected %h", obs, exp_v); else n_pass++;
    iss_valid = 1'b1; iss_addr = 5'd6;
    tick();
    iss_addr = 5'd0;
    tick(); idle();
    exp_q.push_back(64'h40); obs = 64'(busy); exp_v = exp_q.pop_front(); n_checks++;
    if (obs !== exp_v) $display("FAIL issue_x0_ignored: got %h expected %h", obs, exp_v); else n_pass++;
    we = 2'b10; wa = {5'd6, 5'd0}; wd = {32'h66, 32'h0};
    tick(); idle();
    exp_q.push_back(64'h0); obs = 64'(busy); exp_v = exp_q.pop_front(); n_checks++;
    if (obs !== exp_v) $display("FAIL port1_clears: got %h expected %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_x0_saturation();
    we = 2'b01; wa = '0; wd = {32'h0, 32'hFFFFFFFF};
    tick();
    exp_q.push_back(64'd1); obs = 64'(x0_wr_cnt); exp_v = exp_q.pop_front(); n_checks++;
    if (obs !== exp_v) $display("FAIL x0_first: got %h expected %h", obs, exp_v); else n_pass++;
    for (int i = 1; i < 254; i++) tick();
    exp_q.push_back(64'd254); obs = 64'(x0_wr_cnt); exp_v = exp_q.pop_front(); n_checks++;
    if (obs !== exp_v) $display("FAIL x0_254: got %h expected %h", obs, exp_v); else n_pass++;
    we = 2'b11; wd = '1;
    tick();
    exp_q.push_back(64'd255); obs = 64'(x0_wr_cnt); exp_v = exp_q.pop_front(); n_checks++;
    if (obs !== exp_v) $display("FAIL x0_double_sat: got %h expected %h", obs, exp_v); else n_pass++;
    we = 2'b01;
    for (int i = 0; i < 6; i++) tick();
    idle(); ra = '0;
    #1;
    exp_q.push_back(64'd255); obs = 64'(x0_wr_cnt); exp_v = exp_q.pop_front(); n_checks++;
    if (obs !== exp_v) $display("FAIL x0_hold: got %h expected %h", obs, exp_v); else n_pass++;
    exp_q.push_back(64'd0); obs = rd; exp_v = exp_q.pop_front(); n_checks++;
    if (obs !== exp_v) $display("FAIL x0_reads_zero: got %h expected %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 4; i++) begin
      we = 2'b01; wa = {5'd0, 5'(i)}; wd = {32'h0, 32'h01010101 * i};
      tick();
    end
    idle(); iss_valid = 1'b1; iss_addr = 5'd2;
    tick(); idle(); ra = {5'd4, 5'd2};
    #1;
    exp_q.push_back({32'h04040404, 32'h02020202}); obs = rd; exp_v = exp_q.pop_front(); n_checks++;
    if (obs !== exp_v) $display("FAIL pre_reset_data: got %h expected %h", obs, exp_v); else n_pass++;
    rst_n = 1'b0; we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'hCAFE0009};
    iss_valid = 1'b1; iss_addr = 5'd9;
    tick();
    rst_n = 1'b1; idle();
    #1;
    exp_q.push_back(64'd0); obs = 64'(busy); exp_v = exp_q.pop_front(); n_checks++;
    if (obs !== exp_v) $display("FAIL mid_reset_busy: got %h expected %h", obs, exp_v); else n_pass++;
    exp_q.push_back(64'd0); obs = 64'(x0_wr_cnt); exp_v = exp_q.pop_front(); n_checks++;
    if (obs !== exp_v) $display("FAIL mid_reset_cnt: got %h expected %h", obs, exp_v); else n_pass++;
    for (int i = 0; i < NREGS; i += 2) begin
      ra = {5'(i + 1), 5'(i)};
      #1;
      exp_q.push_back(64'd0); obs = rd; exp_v = exp_q.pop_front(); n_checks++;
      if (obs !== exp_v) $display("FAIL mid_reset_read[%0d]: got %h expected %h", i, obs, exp_v); else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
    m_busy = '0;
    m_cnt  = 0;
    for (int it = 0; it < 300; it++) begin
      idle(); ra = 10'($urandom);
      #1;
      for (int j = 0; j < NRD; j++) begin
        a = ra[j*AW +: AW];
        exp_q.push_back({31'h0, m_busy[a], m_regs[a]});
        obs = {31'h0, rd_busy[j], rd[j*XLEN +: XLEN]}; exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL rand_read it%0d port%0d: got %h expected %h", it, j, obs, exp_v); else n_pass++;
      end
      exp_q.push_back({24'h0, 8'(m_cnt), m_busy});
      obs = {24'h0, x0_wr_cnt, busy}; exp_v = exp_q.pop_front(); n_checks++;
      if (obs !== exp_v) $display("FAIL rand_state it%0d: got %h expected %h", it, obs, exp_v); else n_pass++;
      we = 2'($urandom);
      wa = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wd = {$urandom, $urandom};
      iss_valid = 1'($urandom);
      iss_addr = 5'($urandom_range(0, 7));
      for (int r = 1; r < NREGS; r++) begin
        m_clr = (we[0] && wa[4:0] == 5'(r)) || (we[1] && wa[9:5] == 5'(r));
        if (iss_valid && iss_addr == 5'(r)) m_busy[r] = 1'b1;
        else if (m_clr) m_busy[r] = 1'b0;
      end
      if (we[0] && wa[4:0] == 5'd0) m_cnt = m_cnt + 1;
      if (we[1] && wa[9:5] == 5'd0) m_cnt = m_cnt + 1;
      if (m_cnt > 255) m_cnt = 255;
      if (we[0] && wa[4:0] != 5'd0) m_regs[wa[4:0]] = wd[31:0];
      if (we[1] && wa[9:5] != 5'd0) m_regs[wa[9:5]] = wd[63:32];
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_write();
    test_conflict();
    test_scoreboard();
    test_x0_saturation();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
